key_encoder: RTL and testbench
==============================

KEY_ENCODER -- requirements
Module: key_encoder

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000, meaning the debounce stability window in clk cycles (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all logic on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning reset; reset is synchronous and active-low.
REQ-004 SHALL have port key, input, 8, meaning raw push-buttons, active-low, asynchronous to clk; bit i pressed when key[i]=0.
REQ-005 SHALL have port code, output, 3, meaning the index of the last accepted key (key[i] gives code=i).
REQ-006 SHALL have port valid, output, 1, meaning a one-cycle pulse on each accepted debounced press.
REQ-007 SHALL have port held, output, 1, meaning a level that is high while the accepted key remains pressed.
REQ-008 SHALL have port multi, output, 1, meaning a one-cycle pulse when a stable multi-key press is rejected.

Function
REQ-009 SHALL pass key through a 2-flop synchronizer (reset value 8'hFF); all decisions use the synchronized value key_s only.
REQ-010 SHALL implement states IDLE, DEBOUNCE, PRESSED, RELEASE, WAIT_REL.
REQ-011 IDLE: on key_s != 8'hFF, SHALL capture key_s into sample, clear the counter, and go to DEBOUNCE.
REQ-012 DEBOUNCE: if key_s != sample, SHALL recapture sample and clear the counter; if the new key_s == 8'hFF, SHALL return to IDLE.
REQ-013 DEBOUNCE: when key_s == sample and the counter == DB_CYCLES-1, SHALL evaluate sample: exactly one zero bit gives PRESSED, valid=1, and code=index; two or more zero bits give WAIT_REL, multi=1, with code unchanged.
REQ-014 Latency SHALL be exactly: a clean press applied before clock edge 1 gives valid high after edge 3+DB_CYCLES, for one cycle.
REQ-015 PRESSED: held SHALL be 1; on key_s != sample, SHALL clear the counter and go to RELEASE with held=0 on the next cycle.
REQ-016 RELEASE/WAIT_REL: SHALL require key_s == 8'hFF for DB_CYCLES consecutive cycles, then go to IDLE; any non-FF value SHALL clear the counter and stay in the state.
REQ-017 A second key added while in PRESSED SHALL leave PRESSED via RELEASE; no new valid SHALL occur until all keys are released and a fresh press is debounced.
REQ-018 code SHALL hold its value between accepted presses; valid and multi SHALL never be high in the same cycle.
REQ-019 The counter SHALL be $clog2(DB_CYCLES) bits wide, saturate-free, and SHALL only count in DEBOUNCE, RELEASE and WAIT_REL.

Reset
REQ-020 While rst_n=0 at a clk edge, the block SHALL set state=IDLE, counter=0, sample=8'hFF, sync flops=8'hFF, code=3'd0, valid=0, held=0, multi=0.
REQ-021 Reset asserted mid-press SHALL abort without a valid pulse; after release of reset, a still-held key SHALL be debounced afresh as a new press.

Structure
REQ-022 Package key_pkg SHALL hold the state enum, the 8'hFF idle constant, and the one-zero/index helper function.
REQ-023 The synchronizer SHALL be a sub-module key_sync (parameterized width, reset value all-ones); everything else stays in key_encoder.

Verification (benches SHALL use DB_CYCLES=4)
REQ-024 Scenario: clean press key=8'hFB held 20 cycles -> valid pulse after edge 7, code=3'd2, held=1 until release plus sync delay.
REQ-025 Scenario: bounce 8'hFB/8'hFF toggling every 2 cycles for 12 cycles, then stable -> exactly one valid, counted from the last toggle.
REQ-026 Scenario: key=8'hF6 (keys 0 and 3) stable -> one multi pulse, no valid, code unchanged, and held=0 throughout.
REQ-027 Scenario: press key 7 (8'h7F), accepted, then add key 1 (8'h7D), then release all -> held drops, no second valid, return to IDLE after 4 stable FF cycles.
REQ-028 Scenario: rst_n=0 for 1 cycle in DEBOUNCE with 8'hEF held -> no valid; after reset, valid with code=3'd4 at edge 3+4 after reset release.
REQ-029 Scenario: press 8'hFE, release, press 8'hBF -> two valid pulses with code 0 then 6, and code holds 0 between them.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button key encoder.
package key_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        PRESSED  = 3'd2,
        RELEASE  = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    // All eight buttons released (keys are active-low).
    localparam logic [7:0] KEY_IDLE = 8'hFF;

    // Result of classifying a stable key pattern.
    typedef struct packed {
        logic       one;   // exactly one key pressed
        logic [2:0] idx;   // index of the pressed key when one is set
    } key_dec_t;

    // Counts the zero bits of a pattern and reports the index of the zero
    // when there is exactly one of them.
    function automatic key_dec_t decode_key(input logic [7:0] v);
        key_dec_t r;
        int       zeros;
        r     = '0;
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
            if (!v[i]) begin
                zeros = zeros + 1;
                r.idx = 3'(i);
            end
        end
        r.one = (zeros == 1);
        return r;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer bringing asynchronous button levels into the clk domain.
module key_sync #(
    parameter int              DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] sync_p0;
    logic [DATA_W-1:0] sync_p1;

    // Metastability chain; reset to the "nothing pressed" level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/key_encoder.sv
// Debounced 8-button encoder: accepts single stable presses, reports the key
// index with a one-cycle valid pulse, and rejects stable multi-key presses.
module key_encoder
    import key_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key,
    output logic [2:0] code,
    output logic       valid,
    output logic       held,
    output logic       multi
);

    localparam int              CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [7:0]       key_s;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [7:0]       sample, sample_nx;
    logic [2:0]       code_nx;
    logic             valid_nx, held_nx, multi_nx;
    key_dec_t         dec;

    key_sync #(
        .DATA_W  (8),
        .RST_VAL (KEY_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key),
        .q     (key_s)
    );

    // State, counter, captured pattern and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sample <= KEY_IDLE;
            code   <= 3'd0;
            valid  <= 1'b0;
            held   <= 1'b0;
            multi  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            sample <= sample_nx;
            code   <= code_nx;
            valid  <= valid_nx;
            held   <= held_nx;
            multi  <= multi_nx;
        end
    end

    // Next-state logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        sample_nx = sample;
        code_nx   = code;
        valid_nx  = 1'b0;
        held_nx   = 1'b0;
        multi_nx  = 1'b0;
        dec       = decode_key(sample);

        case (state)
            IDLE: begin
                if (key_s != KEY_IDLE) begin
                    sample_nx = key_s;
                    cnt_nx    = '0;
                    state_nx  = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (key_s != sample) begin
                    // Pattern moved: restart the stability window.
                    cnt_nx = '0;
                    if (key_s == KEY_IDLE) begin
                        sample_nx = KEY_IDLE;
                        state_nx  = IDLE;
                    end else begin
                        sample_nx = key_s;
                    end
                end else if (cnt == CNT_MAX) begin
                    cnt_nx = '0;
                    if (dec.one) begin
                        state_nx = PRESSED;
                        valid_nx = 1'b1;
                        held_nx  = 1'b1;
                        code_nx  = dec.idx;
                    end else begin
                        // sample is never all-ones here, so this is 2+ keys.
                        state_nx = WAIT_REL;
                        multi_nx = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            PRESSED: begin
                if (key_s != sample) begin
                    // Release or an added key both end the press.
                    cnt_nx   = '0;
                    state_nx = RELEASE;
                end else begin
                    held_nx = 1'b1;
                end
            end

            RELEASE, WAIT_REL: begin
                // Wait for a full window of all keys up before re-arming.
                if (key_s != KEY_IDLE) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_MAX) begin
                    cnt_nx    = '0;
                    sample_nx = KEY_IDLE;
                    state_nx  = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            default: begin
                cnt_nx    = '0;
                sample_nx = KEY_IDLE;
                state_nx  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_encoder.sv
// Scoreboard bench for key_encoder with a short debounce window.
module tb_key_encoder;

    localparam int DB = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] key;
    logic [2:0] code;
    logic       valid;
    logic       held;
    logic       multi;

    typedef struct {
        bit         is_multi;
        logic [2:0] code;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    key_encoder #(.DB_CYCLES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key),
        .code  (code),
        .valid (valid),
        .held  (held),
        .multi (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_evt(input bit is_multi, input logic [2:0] c, input int at);
        exp_t e;
        e.is_multi = is_multi;
        e.code     = c;
        e.cyc      = at;
        sb.push_back(e);
    endtask

    // Monitor: every valid/multi pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (valid === 1'b1 || multi === 1'b1) begin
            chk("valid_multi_exclusive", int'(valid & multi), 0);
            if (sb.size() == 0) begin
                chk("unexpected_event", int'({valid, multi}), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("event_kind_multi", int'(multi), int'(e.is_multi));
                chk("event_code", int'(code), int'(e.code));
                chk("event_cycle", cyc, e.cyc);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int m;
        key   = 8'hFF;
        rst_n = 1'b0;
        step(3);
        chk("reset_code", int'(code), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_held", int'(held), 0);
        chk("reset_multi", int'(multi), 0);
        rst_n = 1'b1;
        step(3);

        // Clean press of key 2.
        n   = cyc;
        key = 8'hFB;
        expect_evt(1'b0, 3'd2, n + 3 + DB);
        step(7);
        chk("s1_held_on", int'(held), 1);
        step(13);
        chk("s1_held_long", int'(held), 1);
        m   = cyc;
        key = 8'hFF;
        step(2);
        chk("s1_held_sync_delay", int'(held), 1);
        step(1);
        chk("s1_held_off", int'(held), 0);
        step(8);

        // Bouncing key 2, then stable.
        for (int i = 0; i < 6; i++) begin
            key = (i % 2 == 0) ? 8'hFB : 8'hFF;
            step(2);
        end
        key = 8'hFB;
        expect_evt(1'b0, 3'd2, cyc + 3 + DB);
        step(10);
        key = 8'hFF;
        step(10);

        // Two keys at once: rejected, code keeps 2.
        n   = cyc;
        key = 8'hF6;
        expect_evt(1'b1, 3'd2, n + 3 + DB);
        step(7);
        chk("s3_held_low_a", int'(held), 0);
        step(3);
        chk("s3_held_low_b", int'(held), 0);
        chk("s3_code_kept", int'(code), 2);
        key = 8'hFF;
        step(10);

        // Key 7 accepted, key 1 added, release, then press exactly when idle.
        n   = cyc;
        key = 8'h7F;
        expect_evt(1'b0, 3'd7, n + 3 + DB);
        step(10);
        key = 8'h7D;
        step(2);
        chk("s4_held_before_drop", int'(held), 1);
        step(1);
        chk("s4_held_drop", int'(held), 0);
        step(3);
        key = 8'hFF;
        step(4);
        key = 8'hFE;
        expect_evt(1'b0, 3'd0, cyc + 3 + DB);
        step(10);
        chk("s6_held_key0", int'(held), 1);
        key = 8'hFF;
        step(4);
        chk("s6_code_hold_a", int'(code), 0);
        step(6);
        chk("s6_code_hold_b", int'(code), 0);
        key = 8'hBF;
        expect_evt(1'b0, 3'd6, cyc + 3 + DB);
        step(10);
        chk("s6_code_key6", int'(code), 6);
        key = 8'hFF;
        step(10);

        // Reset pulse during debounce of key 4.
        key = 8'hEF;
        step(4);
        rst_n = 1'b0;
        step(1);
        chk("s5_reset_code", int'(code), 0);
        chk("s5_reset_held", int'(held), 0);
        rst_n = 1'b1;
        expect_evt(1'b0, 3'd4, cyc + 3 + DB);
        step(10);
        key = 8'hFF;
        step(12);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
